// File: rtl/sand_pkg.sv
// Shared types and helpers for the sand region sequencer.
// The x-start helper serves the optional SAND_ALT_OFFSET_EN grid shift.
package sand_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        EVAL,
        WRITE,
        NEXT
    } sand_state_t;

    localparam int SAND_ADDR_W = 24;
    localparam int SAND_DATA_W = 16;

    // Odd frames start each row half a region in so region seams alternate.
    function automatic int row_x_start(input logic parity, input int region_w);
        return parity ? (region_w / 2) : 0;
    endfunction

endpackage

// File: rtl/sand_region_addr_gen.sv
// Region position tracker: x/y, incremental row base address, edge flags, frame end.
// SAND_ALT_OFFSET_EN adds a frame parity bit that shifts the region grid on odd frames.
module sand_region_addr_gen
    import sand_pkg::*;
#(
    parameter int ROW_WORDS = 80,
    parameter int ROWS      = 480,
    parameter int REGION_W  = 2,
    parameter int ADDR_W    = SAND_ADDR_W,
    parameter int BASE_ADDR = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic              step,
    output logic [ADDR_W-1:0] region_addr,
    output logic              first_col,
    output logic              last_col,
    output logic              bottom,
    output logic              frame_end
);

    localparam int XW = $clog2(ROW_WORDS + 1);
    localparam int YW = $clog2(ROWS + 1);
    localparam logic [XW-1:0] X_LAST_FULL = XW'(ROW_WORDS - REGION_W);
    localparam logic [YW-1:0] Y_LAST      = YW'(ROWS - 2);

    logic [XW-1:0]     x;
    logic [XW-1:0]     x_first;
    logic [XW-1:0]     x_last;
    logic [YW-1:0]     y;
    logic [ADDR_W-1:0] row_base;
    logic              parity;

`ifdef SAND_ALT_OFFSET_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            parity <= 1'b0;
        else if (frame_end)
            parity <= ~parity;
    end
`else
    assign parity = 1'b0;
`endif

    assign x_first     = XW'(row_x_start(parity, REGION_W));
    assign x_last      = X_LAST_FULL - x_first;
    assign first_col   = (x == x_first);
    assign last_col    = (x == x_last);
    assign bottom      = (y == Y_LAST);
    assign frame_end   = step && last_col && bottom;
    assign region_addr = row_base + ADDR_W'(x);

    // row_base tracks BASE_ADDR + y*ROW_WORDS by accumulation, avoiding a multiplier.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            x        <= '0;
            y        <= '0;
            row_base <= '0;
        end else if (load) begin
            x        <= x_first;
            y        <= '0;
            row_base <= ADDR_W'(BASE_ADDR);
        end else if (step) begin
            if (last_col) begin
                x        <= x_first;
                y        <= y + YW'(1);
                row_base <= row_base + ADDR_W'(ROW_WORDS);
            end else begin
                x <= x + XW'(REGION_W);
            end
        end
    end

endmodule

// File: rtl/sand_region_sequencer.sv
// Sweeps REGION_W x 2-row regions over an Avalon-MM SDRAM master for the physics core.
// Optional grid offset on odd frames: define SAND_ALT_OFFSET_EN.
module sand_region_sequencer
    import sand_pkg::*;
#(
    parameter int ROW_WORDS = 80,
    parameter int ROWS      = 480,
    parameter int REGION_W  = 2,
    parameter int ADDR_W    = SAND_ADDR_W,
    parameter int DATA_W    = SAND_DATA_W,
    parameter int BASE_ADDR = 0
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    output logic                         busy,
    output logic                         frame_done,
    output logic [ADDR_W-1:0]            mem_address,
    output logic                         mem_read,
    output logic                         mem_write,
    output logic [DATA_W-1:0]            mem_writedata,
    input  logic                         mem_waitrequest,
    input  logic                         mem_readdatavalid,
    input  logic [DATA_W-1:0]            mem_readdata,
    output logic [REGION_W*DATA_W-1:0]   phys_region,
    output logic [REGION_W*DATA_W-1:0]   phys_floor,
    output logic                         phys_valid,
    output logic                         phys_first_col,
    output logic                         phys_last_col,
    output logic                         phys_bottom,
    input  logic [REGION_W*DATA_W-1:0]   phys_new_region,
    input  logic [REGION_W*DATA_W-1:0]   phys_new_floor
);

    localparam int NW = 2 * REGION_W;
    localparam int CW = $clog2(NW + 1);
    localparam int IW = $clog2(NW);
    localparam logic [CW-1:0] ALL_WORDS = CW'(NW);
    localparam logic [CW-1:0] LAST_IDX  = CW'(NW - 1);

    sand_state_t       state, state_nxt;
    logic [CW-1:0]     rd_cnt, ret_cnt, wr_cnt;
    logic [DATA_W-1:0] rd_buf [NW];
    logic [DATA_W-1:0] wr_buf [NW];
    logic [ADDR_W-1:0] region_addr;
    logic              first_col, last_col, bottom, frame_end;
    logic              load, step, ret_last, wr_accept, wr_last;
    logic              frame_done_q;

    // Slots 0..REGION_W-1 are the region row, the rest sit one screen row below.
    function automatic logic [ADDR_W-1:0] word_offset(input logic [CW-1:0] idx);
        if (idx < CW'(REGION_W))
            return ADDR_W'(idx);
        return ADDR_W'(ROW_WORDS) + ADDR_W'(idx) - ADDR_W'(REGION_W);
    endfunction

    sand_region_addr_gen #(
        .ROW_WORDS (ROW_WORDS),
        .ROWS      (ROWS),
        .REGION_W  (REGION_W),
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE_ADDR)
    ) u_addr_gen (
        .clock       (clock),
        .reset       (reset),
        .load        (load),
        .step        (step),
        .region_addr (region_addr),
        .first_col   (first_col),
        .last_col    (last_col),
        .bottom      (bottom),
        .frame_end   (frame_end)
    );

    assign load      = (state == IDLE) && start;
    assign step      = (state == NEXT);
    assign ret_last  = (state == READ) && mem_readdatavalid && (ret_cnt == LAST_IDX);
    assign wr_accept = (state == WRITE) && !mem_waitrequest;
    assign wr_last   = wr_accept && (wr_cnt == LAST_IDX);

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = '0;
        mem_writedata = '0;
        phys_valid    = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = READ;
            READ: begin
                if (rd_cnt != ALL_WORDS) begin
                    mem_read    = 1'b1;
                    mem_address = region_addr + word_offset(rd_cnt);
                end
                if (ret_last) state_nxt = EVAL;
            end
            EVAL: begin
                phys_valid = 1'b1;
                state_nxt  = WRITE;
            end
            WRITE: begin
                mem_write     = 1'b1;
                mem_address   = region_addr + word_offset(wr_cnt);
                mem_writedata = wr_buf[wr_cnt[IW-1:0]];
                if (wr_last) state_nxt = NEXT;
            end
            NEXT:    state_nxt = frame_end ? IDLE : READ;
            default: state_nxt = IDLE;
        endcase
    end

    // Issue and return counts run independently so reads can stay pipelined.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_cnt       <= '0;
            ret_cnt      <= '0;
            wr_cnt       <= '0;
            frame_done_q <= 1'b0;
            for (int k = 0; k < NW; k++) begin
                rd_buf[k] <= '0;
                wr_buf[k] <= '0;
            end
        end else begin
            frame_done_q <= frame_end;
            case (state)
                IDLE, NEXT: begin
                    rd_cnt  <= '0;
                    ret_cnt <= '0;
                    wr_cnt  <= '0;
                end
                READ: begin
                    if (mem_read && !mem_waitrequest)
                        rd_cnt <= rd_cnt + CW'(1);
                    if (mem_readdatavalid && (ret_cnt != ALL_WORDS)) begin
                        rd_buf[ret_cnt[IW-1:0]] <= mem_readdata;
                        ret_cnt                 <= ret_cnt + CW'(1);
                    end
                end
                EVAL: begin
                    for (int k = 0; k < REGION_W; k++) begin
                        wr_buf[k]            <= phys_new_region[(REGION_W-1-k)*DATA_W +: DATA_W];
                        wr_buf[REGION_W + k] <= phys_new_floor[(REGION_W-1-k)*DATA_W +: DATA_W];
                    end
                end
                WRITE: if (wr_accept) wr_cnt <= wr_cnt + CW'(1);
                default: ;
            endcase
        end
    end

    always_comb begin
        phys_region = '0;
        phys_floor  = '0;
        if (state == EVAL) begin
            for (int k = 0; k < REGION_W; k++) begin
                phys_region[(REGION_W-1-k)*DATA_W +: DATA_W] = rd_buf[k];
                phys_floor[(REGION_W-1-k)*DATA_W +: DATA_W]  = rd_buf[REGION_W + k];
            end
        end
    end

    assign phys_first_col = (state == EVAL) && first_col;
    assign phys_last_col  = (state == EVAL) && last_col;
    assign phys_bottom    = (state == EVAL) && bottom;
    assign busy           = (state != IDLE);
    assign frame_done     = frame_done_q;

endmodule

// File: tb/tb_sand_region_sequencer.sv
// Scoreboard bench for sand_region_sequencer: a frame-level reference model fills
// expectation queues; a negedge monitor pops and compares against the Avalon slave model.
module tb_sand_region_sequencer;

    localparam int ROW_WORDS = 8;
    localparam int ROWS      = 4;
    localparam int REGION_W  = 2;
    localparam int ADDR_W    = 24;
    localparam int DATA_W    = 16;
    localparam int BASE_ADDR = 0;
    localparam int RW        = REGION_W * DATA_W;
    localparam int MEM_N     = ROW_WORDS * ROWS;
    localparam int PERIOD    = 4 * REGION_W + 3;

    typedef struct packed { logic [ADDR_W-1:0] a; logic [DATA_W-1:0] d; } wr_t;
    typedef struct packed { logic [RW-1:0] r; logic [RW-1:0] f; logic [2:0] fl; } ev_t;
    typedef struct packed { logic [31:0] due; logic [DATA_W-1:0] d; } pend_t;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              busy, frame_done, mem_read, mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_writedata;
    logic              mem_waitrequest   = 1'b0;
    logic              mem_readdatavalid = 1'b0;
    logic [DATA_W-1:0] mem_readdata      = '0;
    logic [RW-1:0]     phys_region, phys_floor, phys_new_region, phys_new_floor;
    logic              phys_valid, phys_first_col, phys_last_col, phys_bottom;

    logic [DATA_W-1:0] mem     [MEM_N];
    logic [DATA_W-1:0] ref_mem [MEM_N];
    logic [RW-1:0]     resp_r  [256];
    logic [RW-1:0]     resp_f  [256];
    logic [7:0]        eval_idx = '0;

    logic [ADDR_W-1:0] exp_rd_q [$];
    wr_t               exp_wr_q [$];
    ev_t               exp_ev_q [$];
    pend_t             pend_q   [$];

    int n_tests = 0, n_fail = 0, cyc = 0, fd_cnt = 0;
    int wait_pct = 0, lat_min = 1, lat_max = 1;
    int rd_seen = 0, wr_seen = 0, rd_stall = 0, wr_stall = 0, last_ev = 0;
    bit chk_period = 1'b0, have_ev = 1'b0, dir_stall = 1'b0, frame_par = 1'b0;
    bit hold_rd = 1'b0, hold_wr = 1'b0;
    logic [ADDR_W-1:0] hold_addr = '0;
    logic [DATA_W-1:0] hold_data = '0;

    sand_region_sequencer #(
        .ROW_WORDS (ROW_WORDS), .ROWS (ROWS), .REGION_W (REGION_W),
        .ADDR_W (ADDR_W), .DATA_W (DATA_W), .BASE_ADDR (BASE_ADDR)
    ) dut (
        .clock (clock), .reset (reset), .start (start), .busy (busy),
        .frame_done (frame_done), .mem_address (mem_address), .mem_read (mem_read),
        .mem_write (mem_write), .mem_writedata (mem_writedata),
        .mem_waitrequest (mem_waitrequest), .mem_readdatavalid (mem_readdatavalid),
        .mem_readdata (mem_readdata), .phys_region (phys_region), .phys_floor (phys_floor),
        .phys_valid (phys_valid), .phys_first_col (phys_first_col),
        .phys_last_col (phys_last_col), .phys_bottom (phys_bottom),
        .phys_new_region (phys_new_region), .phys_new_floor (phys_new_floor)
    );

    always #5 clock = ~clock;

    assign phys_new_region = resp_r[eval_idx];
    assign phys_new_floor  = resp_f[eval_idx];
    always @(posedge clock) if (phys_valid) eval_idx <= eval_idx + 8'd1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_msg(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: no matching expectation (t=%0t)", name, $time);
    endtask

    // Reference model: walks the frame's region grid and predicts every transaction.
    task automatic build_frame();
        int  x0, xl, a, r;
        ev_t e;
        wr_t w;
        x0 = 0;
`ifdef SAND_ALT_OFFSET_EN
        if (frame_par) x0 = REGION_W / 2;
`endif
        xl = ROW_WORDS - REGION_W - x0;
        r  = int'(eval_idx);
        for (int y = 0; y <= ROWS - 2; y++) begin
            for (int x = x0; x <= xl; x += REGION_W) begin
                a = y * ROW_WORDS + x;
                e = '0;
                for (int k = 0; k < REGION_W; k++) begin
                    exp_rd_q.push_back(ADDR_W'(BASE_ADDR + a + k));
                    e.r = (e.r << DATA_W) | RW'(ref_mem[a + k]);
                end
                for (int k = 0; k < REGION_W; k++) begin
                    exp_rd_q.push_back(ADDR_W'(BASE_ADDR + a + ROW_WORDS + k));
                    e.f = (e.f << DATA_W) | RW'(ref_mem[a + ROW_WORDS + k]);
                end
                e.fl = {(x == x0), (x == xl), (y == ROWS - 2)};
                exp_ev_q.push_back(e);
                for (int k = 0; k < REGION_W; k++) begin
                    w.a = ADDR_W'(BASE_ADDR + a + k);
                    w.d = resp_r[r % 256][(REGION_W-1-k)*DATA_W +: DATA_W];
                    exp_wr_q.push_back(w);
                    ref_mem[a + k] = w.d;
                end
                for (int k = 0; k < REGION_W; k++) begin
                    w.a = ADDR_W'(BASE_ADDR + a + ROW_WORDS + k);
                    w.d = resp_f[r % 256][(REGION_W-1-k)*DATA_W +: DATA_W];
                    exp_wr_q.push_back(w);
                    ref_mem[a + ROW_WORDS + k] = w.d;
                end
                r++;
            end
        end
    endtask

    // Avalon slave: waitrequest policy and in-order pipelined read returns.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            cyc++;
            if (reset) begin
                pend_q.delete();
                mem_waitrequest   = 1'b0;
                mem_readdatavalid = 1'b0;
            end else begin
                if (dir_stall && mem_read && rd_seen == 1 && rd_stall < 3) begin
                    mem_waitrequest = 1'b1;
                    rd_stall++;
                end else if (dir_stall && mem_write && wr_seen == 2 && wr_stall < 3) begin
                    mem_waitrequest = 1'b1;
                    wr_stall++;
                end else begin
                    mem_waitrequest = ($urandom_range(99) < wait_pct);
                end
                if (pend_q.size() > 0 && int'(pend_q[0].due) <= cyc) begin
                    mem_readdatavalid = 1'b1;
                    mem_readdata      = pend_q.pop_front().d;
                end else begin
                    mem_readdatavalid = 1'b0;
                    mem_readdata      = DATA_W'($urandom);
                end
            end
        end
    end

    // Monitor: every accepted transfer or EVAL pops the scoreboard.
    always @(negedge clock) begin
        if (reset) begin
            hold_rd = 1'b0;
            hold_wr = 1'b0;
        end else begin
            chk("rd_wr_overlap", 64'(mem_read & mem_write), 64'd0);
            if (hold_rd) chk("rd_hold", 64'({mem_read, mem_address}), 64'({1'b1, hold_addr}));
            if (hold_wr) chk("wr_hold", 64'({mem_write, mem_address, mem_writedata}),
                             64'({1'b1, hold_addr, hold_data}));
            hold_rd   = mem_read && mem_waitrequest;
            hold_wr   = mem_write && mem_waitrequest;
            hold_addr = mem_address;
            hold_data = mem_writedata;
            if (mem_read && !mem_waitrequest) begin
                pend_t p;
                int idx;
                idx = int'(mem_address) - BASE_ADDR;
                if (exp_rd_q.size() == 0) fail_msg("unexpected_read");
                else chk("rd_addr", 64'(mem_address), 64'(exp_rd_q.pop_front()));
                p.due = 32'(cyc + int'($urandom_range(lat_max, lat_min)));
                p.d   = (idx >= 0 && idx < MEM_N) ? mem[idx] : DATA_W'(16'hDEAD);
                pend_q.push_back(p);
                rd_seen++;
            end
            if (mem_write && !mem_waitrequest) begin
                int idx;
                idx = int'(mem_address) - BASE_ADDR;
                if (exp_wr_q.size() == 0) fail_msg("unexpected_write");
                else chk("wr_addr_data", 64'({mem_address, mem_writedata}), 64'(exp_wr_q.pop_front()));
                if (idx >= 0 && idx < MEM_N) mem[idx] = mem_writedata;
                wr_seen++;
            end
            if (phys_valid) begin
                chk("busy_in_eval", 64'(busy), 64'd1);
                if (exp_ev_q.size() == 0) fail_msg("unexpected_eval");
                else begin
                    ev_t e;
                    e = exp_ev_q.pop_front();
                    chk("phys_region", 64'(phys_region), 64'(e.r));
                    chk("phys_floor", 64'(phys_floor), 64'(e.f));
                    chk("phys_flags", 64'({phys_first_col, phys_last_col, phys_bottom}), 64'(e.fl));
                end
                if (chk_period && have_ev) chk("eval_period", 64'(cyc - last_ev), 64'(PERIOD));
                have_ev = 1'b1;
                last_ev = cyc;
            end
            if (frame_done) begin
                fd_cnt++;
                chk("busy_at_done", 64'(busy), 64'd0);
            end
        end
    end

    task automatic pulse_start();
        @(posedge clock);
        #2 start = 1'b1;
        @(posedge clock);
        #1 chk("busy_after_start", 64'(busy), 64'd1);
        #1 start = 1'b0;
    endtask

    task automatic run_frame(input int wp, input int lmin, input int lmax,
                             input bit per, input bit dir);
        int fd0;
        wait_pct = wp; lat_min = lmin; lat_max = lmax; chk_period = per; dir_stall = dir;
        rd_seen = 0; wr_seen = 0; rd_stall = 0; wr_stall = 0; have_ev = 1'b0;
        fd0 = fd_cnt;
        build_frame();
        pulse_start();
        repeat (3) @(posedge clock);
        #2 start = 1'b1;
        @(posedge clock);
        #2 start = 1'b0;
        for (int i = 0; i < 20000 && fd_cnt == fd0; i++) @(negedge clock);
        if (fd_cnt == fd0) fail_msg("frame_done_timeout");
        repeat (4) @(negedge clock);
        chk("frame_done_once", 64'(fd_cnt - fd0), 64'd1);
        chk("rd_q_drained", 64'(exp_rd_q.size()), 64'd0);
        chk("wr_q_drained", 64'(exp_wr_q.size()), 64'd0);
        chk("ev_q_drained", 64'(exp_ev_q.size()), 64'd0);
        if (dir) chk("stalls_applied", 64'({rd_stall[3:0], wr_stall[3:0]}), 64'h33);
        frame_par = ~frame_par;
    endtask

    task automatic check_outputs_zero(input string name);
        chk({name, "_ctl"}, 64'({busy, frame_done, mem_read, mem_write, phys_valid,
                                  phys_first_col, phys_last_col, phys_bottom}), 64'd0);
        chk({name, "_addr_data"}, 64'({mem_address, mem_writedata}), 64'd0);
        chk({name, "_phys"}, 64'({phys_region, phys_floor}), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < MEM_N; i++) mem[i] = DATA_W'($urandom);
        mem[0] = 16'h0011; mem[1] = 16'h0022;
        mem[ROW_WORDS] = 16'h0033; mem[ROW_WORDS + 1] = 16'h0044;
        for (int i = 0; i < MEM_N; i++) ref_mem[i] = mem[i];
        for (int i = 0; i < 256; i++) begin
            resp_r[i] = RW'($urandom);
            resp_f[i] = RW'($urandom);
        end
        resp_r[0] = 32'hAAAABBBB;
        resp_f[0] = 32'hCCCCDDDD;

        #3 check_outputs_zero("reset_state");
        repeat (2) @(posedge clock);
        #3 reset = 1'b0;

        run_frame(0, 1, 1, 1'b1, 1'b0);
        chk("first_region_wb0", 64'(mem[0]), 64'hAAAA);
        chk("first_region_wb1", 64'(mem[1]), 64'hBBBB);
        run_frame(0, 1, 1, 1'b0, 1'b1);
        run_frame(0, 4, 4, 1'b0, 1'b0);
        run_frame(30, 1, 4, 1'b0, 1'b0);

        wait_pct = 20; lat_min = 1; lat_max = 3; chk_period = 1'b0; dir_stall = 1'b0;
        build_frame();
        pulse_start();
        for (int i = 0; i < 2000 && !mem_write; i++) @(negedge clock);
        chk("reached_write", 64'(mem_write), 64'd1);
        #2 reset = 1'b1;
        #1 check_outputs_zero("async_reset");
        repeat (2) @(posedge clock);
        #3 reset = 1'b0;
        exp_rd_q.delete();
        exp_wr_q.delete();
        exp_ev_q.delete();
        for (int i = 0; i < MEM_N; i++) ref_mem[i] = mem[i];
        frame_par = 1'b0;
        run_frame(0, 1, 1, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
        $fatal(1);
    end

endmodule
